// File: rtl/div_sequencer_pkg.sv
//==============================================================================
// Module      : div_sequencer_pkg
// Description : Shared constants and types for the iterative divide sequencer.
//               These are the ALU op codes that start it, the FSM state
//               encoding and the default datapath width.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_sequencer_pkg;

    // Default operand/result width; the iteration count equals the width.
    localparam int DIV_WIDTH_DEFAULT = 32;

    // ALUctr encodings that start the sequencer.
    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_MOD = 3'b101;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage : div_sequencer_pkg

`default_nettype wire

// File: rtl/div_sequencer_step.sv
//==============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. It shifts the
//               next dividend bit out of the quotient register into the
//               partial remainder, does a trial subtract of the divisor and
//               shifts the resulting quotient bit into the quotient LSB.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] r;
    logic [WIDTH:0] d;

    // Trial subtract. A borrow (d MSB set) means the divisor did not fit, so
    // the shifted remainder is kept as it is.
    always_comb begin
        r = {rem, quo[WIDTH-1]};
        d = r - {1'b0, divisor};
        if (d[WIDTH] == 1'b0) begin
            rem_next = d[WIDTH-1:0];
        end else begin
            rem_next = r[WIDTH-1:0];
        end
        quo_next = {quo[WIDTH-2:0], ~d[WIDTH]};
    end

endmodule : div_step

`default_nettype wire

// File: rtl/div_sequencer.sv
//==============================================================================
// Module      : div_sequencer
// Description : Sequencer for a shared iterative restoring divider serving
//               the EX-stage DIV (3'b100) and MOD (3'b101) ops. It produces
//               one quotient bit per cycle. While it runs it holds IF/ID/DX
//               with a stall, then pulses res_valid with the quotient or
//               remainder for one cycle.
//               Optional macro DIV_ZERO_FAST_EN: a divide by zero skips the
//               iterations and goes straight from IDLE to DONE.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [2:0]       ALUctr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             mod_q, mod_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic             is_div_op;
    logic             start;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // A valid DIV/MOD from DX starts an operation unless it is being flushed.
    assign is_div_op = (ALUctr == ALU_DIV) || (ALUctr == ALU_MOD);
    assign start     = req_valid && is_div_op && !flush;

    div_step #(
        .WIDTH    (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        mod_d    = mod_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    div_d   = B;
                    mod_d   = (ALUctr == ALU_MOD);
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = A;
                    state_d = ST_RUN;
`ifdef DIV_ZERO_FAST_EN
                    // These are the same values the full iteration would give.
                    if (B == '0) begin
                        state_d  = ST_DONE;
                        result_d = (ALUctr == ALU_MOD) ? A : '1;
                    end
`endif
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = mod_q ? step_rem : step_quo;
                end
            end
            ST_DONE: begin
                // Never accept here, so the same instruction cannot restart.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the last result in place.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end

        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Register all state. A synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            mod_q       <= 1'b0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            mod_q       <= mod_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    // The stall covers the accepting cycle and every iteration cycle. It is
    // combinational so the front end freezes in the same cycle a start is seen.
    always_comb begin
        stall = !rst && (((state_q == ST_IDLE) && start) || (state_q == ST_RUN));
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;

endmodule : div_sequencer

`default_nettype wire

// File: tb/tb_div_sequencer.sv
//==============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer. It uses directed and
//               random DIV/MOD operations, checked against an arithmetic
//               reference model of results and cycle timing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_sequencer;

    localparam int          W     = 32;
    localparam logic [2:0]  OP_DIV = 3'b100;
    localparam logic [2:0]  OP_MOD = 3'b101;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [2:0]   ALUctr;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         res_valid;
    logic [W-1:0] result;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] last_result;

    div_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .ALUctr    (ALUctr),
        .A         (A),
        .B         (B),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .res_valid (res_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain unsigned arithmetic, divide by zero defined.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        if (b == 0) return (op == OP_MOD) ? a : {W{1'b1}};
        return (op == OP_MOD) ? (a % b) : (a / b);
    endfunction

    function automatic int model_latency(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 1;
`endif
        return W + 1;
    endfunction

    // Issue one operation at the next falling edge (cycle t). Measure the stall
    // length, the result latency and the result value. Operands are scrambled
    // while it runs. With hold set, req_valid stays high through DONE and the
    // next operands are presented, so the caller's next op starts at t+lat+1.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W-1:0] exp;
        int           exp_lat;
        int           stalls;
        bit           seen;
        exp     = model(op, a, b);
        exp_lat = model_latency(b);
        stalls  = 0;
        seen    = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        ALUctr    = op;
        A         = a;
        B         = b;
        flush     = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            #1;
            if (res_valid) begin
                seen = 1'b1;
                check("latency", W'(k), W'(exp_lat));
                check("result", result, exp);
                check("stall_in_done", {31'd0, stall}, 32'd0);
                check("stall_cycles", W'(stalls), W'(exp_lat));
                if (hold) begin
                    ALUctr = OP_DIV;
                    A      = na;
                    B      = nb;
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                if (stall) stalls++;
                if (k > 0) begin
                    A      = $urandom;
                    B      = $urandom;
                    ALUctr = 3'($urandom);
                end
                @(negedge clk);
            end
        end
        if (!seen) check("timeout_res_valid", 32'd0, 32'd1);
        last_result = exp;
        if (!hold) begin
            @(negedge clk);
            #1;
            check("idle_stall", {31'd0, stall}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("result_hold", result, exp);
        end
    endtask

    initial begin
        bit any_bad;
        rst       = 1'b1;
        req_valid = 1'b0;
        ALUctr    = 3'b000;
        A         = '0;
        B         = '0;
        flush     = 1'b0;
        last_result = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        // Directed cases.
        do_op(OP_DIV, 32'd100, 32'd7, 1'b0, '0, '0);
        do_op(OP_MOD, 32'd100, 32'd7, 1'b0, '0, '0);
        do_op(OP_DIV, 32'hFFFF_FFFF, 32'd1, 1'b0, '0, '0);
        do_op(OP_MOD, 32'd5, 32'd9, 1'b0, '0, '0);
        do_op(OP_DIV, 32'd0, 32'd3, 1'b0, '0, '0);
        do_op(OP_DIV, 32'h1234, 32'd0, 1'b0, '0, '0);
        do_op(OP_MOD, 32'h1234, 32'd0, 1'b0, '0, '0);

        // Back-to-back: the second start must land in the cycle after DONE.
        do_op(OP_DIV, 32'd1000, 32'd10, 1'b1, 32'd77, 32'd5);
        do_op(OP_DIV, 32'd77, 32'd5, 1'b0, '0, '0);

        // A non-divide op must never stall.
        @(negedge clk);
        req_valid = 1'b1;
        ALUctr    = 3'b010;
        any_bad   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (stall || busy) any_bad = 1'b1;
            @(negedge clk);
        end
        check("nondiv_no_stall", {31'd0, any_bad}, 32'd0);
        req_valid = 1'b0;

        // Flush after 10 RUN cycles.
        @(negedge clk);
        req_valid = 1'b1;
        ALUctr    = OP_DIV;
        A         = 32'd1000;
        B         = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall_run", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_res_valid", {31'd0, res_valid}, 32'd0);
        check("flush_result", result, last_result);
        flush     = 1'b0;
        req_valid = 1'b0;
        any_bad   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (res_valid || busy) any_bad = 1'b1;
        end
        check("flush_no_pulse", {31'd0, any_bad}, 32'd0);

        // Reset at RUN cycle 20.
        @(negedge clk);
        req_valid = 1'b1;
        ALUctr    = OP_MOD;
        A         = 32'd123456;
        B         = 32'd789;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_run_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_run_result", result, 32'd0);
        check("rst_run_busy", {31'd0, busy}, 32'd0);
        check("rst_run_res_valid", {31'd0, res_valid}, 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        last_result = '0;
        do_op(OP_DIV, 32'd999, 32'd33, 1'b0, '0, '0);

        // Random operations, including small and zero divisors.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 16));
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op(($urandom_range(0, 1) == 1) ? OP_MOD : OP_DIV, ra, rb, 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_sequencer

`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Sequencer for a shared 32-bit iterative restoring divider serving the EX stage's divide (ALUctr 3'b100) and modulo (ALUctr 3'b101) operations. It accepts a divide or modulo request from the DX pipeline register and runs one quotient bit per cycle. While it runs, it holds the front of the pipeline with `stall`, then presents the quotient or remainder for one cycle so EX can latch it into `ALUout`. It replaces single-cycle `/` and `%`, which close timing poorly.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.

Ports:
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, 1: the DX register holds a valid instruction.
- `ALUctr`, in, 3: ALU control from DX; only 3'b100 (DIV) and 3'b101 (MOD) start the sequencer.
- `A`, in, WIDTH: dividend, unsigned.
- `B`, in, WIDTH: divisor, unsigned.
- `flush`, in, 1: abort any in-flight operation; also blocks a new start.
- `stall`, out, 1: freezes IF, ID and DX; combinational.
- `busy`, out, 1: high in RUN or DONE; registered.
- `res_valid`, out, 1: one-cycle pulse, high in DONE; registered.
- `result`, out, WIDTH: quotient for DIV, remainder for MOD; registered, and holds its value between operations.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - A start is `req_valid && (ALUctr==DIV || ALUctr==MOD) && !flush`.
  - On a start, latch `A`, `B` and the op, clear the iteration counter, clear the remainder register to 0, load the quotient register with `A`, and go to RUN.
  - Any other `ALUctr` value is ignored and never asserts `stall`.
- **RUN**
  - Each cycle performs one restoring step: `r = {rem[WIDTH-1:0], quo[WIDTH-1]}`; `d = r - {1'b0, Bq}`.
  - If `d[WIDTH]==0`: `rem = d` and shift 1 into the quotient LSB. Otherwise: `rem = r` and shift 0 into the quotient LSB.
  - The counter increments each step. After step `WIDTH-1`, the state goes to DONE and `result` is loaded with the quotient or remainder, selected by the latched op.
- **DONE**: `res_valid` is 1 and `stall` is 0, so the pipeline advances past the division instruction at this edge. The next state is always IDLE. A request is never accepted in DONE, which prevents a restart on the same instruction.
- **`stall`** is `!rst && ((IDLE && start) || RUN)`.
- **Divide by zero** returns quotient all-ones and remainder = `A`. The restoring algorithm produces this naturally.
- **Operand changes**: changes on `A`, `B` or `ALUctr` during RUN or DONE have no effect.
- **`flush`**
  - In any state, go to IDLE at the next edge.
  - `res_valid` is not asserted and `result` is unchanged.
  - `stall` drops in the same cycle only if the state is IDLE; from RUN it drops the cycle after.
- **`rst`** takes priority over `flush`. At the reset edge: state IDLE, counter 0, `result` 0, `res_valid` 0, `busy` 0, and internal registers 0. `stall` is 0 while `rst` is high.

## Timing
- A request first seen in IDLE at cycle t gives RUN in cycles t+1 through t+WIDTH, DONE at t+WIDTH+1, and IDLE at t+WIDTH+2.
- `stall` is high in cycles t through t+WIDTH (WIDTH+1 cycles). `res_valid` and `result` are valid in cycle t+WIDTH+1.
- With WIDTH=32: `stall` is high for 33 cycles and the result arrives at t+33.
- Back-to-back operations: a second division can start no earlier than t+WIDTH+2.

## Configuration
- Macro: `DIV_ZERO_FAST_EN`.
- Defined: a start with `B==0` goes directly from IDLE to DONE. `result` is `{WIDTH{1'b1}}` for DIV or `A` for MOD. `stall` is high only in cycle t, and `res_valid` is high at t+1.
- Undefined: divide by zero runs the full WIDTH iterations. The result values are identical; only the latency differs.

## Structure
- Shared package contents:
  - ALU op constants `ALU_DIV=3'b100`, `ALU_MOD=3'b101`.
  - FSM state encoding constants (IDLE/RUN/DONE).
  - Default `WIDTH` of 32.
- Sub-module `div_step`: a combinational single restoring iteration. Inputs are `rem`, `quo` and `divisor`; outputs are the next `rem` and next `quo`. It is instantiated once.

## Test plan
- **DIV basic**: DIV with A=100, B=7 at cycle t → `stall` high for t..t+32, `res_valid` at t+33, `result`=14. The same operands with MOD → `result`=2.
- **Extremes**: DIV with A=0xFFFFFFFF, B=1 → 0xFFFFFFFF. MOD with A=5, B=9 → 5. DIV with A=0, B=3 → 0.
- **Divide by zero**: A=0x1234, B=0.
  - Without the macro: DIV → 0xFFFFFFFF at t+33; MOD → 0x1234 at t+33.
  - With the macro: the same values at t+1, with `stall` high for one cycle only.
- **Flush mid-run**: assert `flush` after 10 RUN cycles → IDLE on the next cycle. `stall` and `busy` drop, no `res_valid` pulse, and `result` keeps its prior value.
- **Back-to-back**: `req_valid` held high through DONE with a second DIV following → the second start occurs at t+34, exactly one start per instruction. A non-divide `ALUctr` (3'b010) with `req_valid` → `stall` never asserted.
- **Reset mid-run**: `rst` asserted at RUN cycle 20 → after the edge, all outputs are 0 and the state is IDLE. A new DIV after reset completes correctly.
